regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32: data width of write-back values and of the register file write port.
REQ-002 Parameter REG_BITS, default 5: register number width; the register file holds 2**REG_BITS registers.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_wb0_valid / in_wb1_valid  input  1 each  write-back requester 0 / 1 holds a valid request.
REQ-006 in_wb0_number / in_wb1_number  input  REG_BITS each  destination register of requester 0 / 1.
REQ-007 in_wb0_value / in_wb1_value  input  XLEN each  value to write for requester 0 / 1.
REQ-008 out_wb0_ready / out_wb1_ready  output  1 each  request of requester 0 / 1 accepted this cycle.
REQ-009 in_issue_valid  input  1  an instruction with a destination register issues this cycle.
REQ-010 in_issue_number  input  REG_BITS  destination register of the issuing instruction.
REQ-011 in_reg_number_1 / in_reg_number_2  input  REG_BITS each  source registers to check for pending writes.
REQ-012 out_busy_1 / out_busy_2  output  1 each  source register 1 / 2 has a pending write.
REQ-013 out_write_enable  output  1  register file write strobe.
REQ-014 out_write_number  output  REG_BITS  register file write index.
REQ-015 out_write_value  output  XLEN  register file write data.

Function
REQ-016 A transfer on port i SHALL occur in any cycle where in_wbi_valid and out_wbi_ready are both 1; at most one transfer SHALL occur per cycle.
REQ-017 out_wbi_ready SHALL be combinational: 1 when in_wbi_valid=1 and port i wins arbitration, else 0; ready SHALL NOT depend on any downstream signal.
REQ-018 With exactly one valid request, that port SHALL win.
REQ-019 With both requests valid, the port selected by the 1-bit priority pointer SHALL win; the loser keeps valid, number and value stable until accepted.
REQ-020 After every cycle with both requests valid, the pointer SHALL move to the losing port; otherwise the pointer SHALL hold.
REQ-021 A transfer accepted in cycle N with number != 0 SHALL drive out_write_enable=1 with that number and value in cycle N+1 for exactly one cycle.
REQ-022 A transfer with number 0 SHALL be accepted and dropped: out_write_enable=0 in cycle N+1 and no scoreboard change.
REQ-023 With no transfer in cycle N, out_write_enable SHALL be 0 in cycle N+1; out_write_number and out_write_value SHALL hold their previous values.
REQ-024 The scoreboard SHALL hold one pending bit per register; bit 0 SHALL read as 0 at all times.
REQ-025 in_issue_valid=1 with in_issue_number != 0 SHALL set the matching pending bit at the next edge.
REQ-026 An accepted transfer with number != 0 SHALL clear the matching pending bit at the same edge.
REQ-027 If set and clear target the same register in the same cycle, set SHALL win and the bit SHALL end at 1.
REQ-028 out_busy_k SHALL be combinational and equal to pending[in_reg_number_k]; it SHALL NOT reflect issues or transfers of the current cycle.

Reset
REQ-029 While rst=1: out_write_enable=0, out_write_number=0, out_write_value=0, all pending bits 0, pointer=0 (requester 0 first), both ready outputs 0.
REQ-030 Assertion of rst mid-operation SHALL discard the pending registered write immediately; the first accept SHALL be possible in the first cycle with rst=0.

Configuration
REQ-031 Macro WB_ARB_RR_EN defined: arbitration SHALL follow REQ-019/020 (round-robin).
REQ-032 Macro WB_ARB_RR_EN undefined: requester 0 SHALL always win when both are valid; no pointer register exists; all other requirements unchanged.

Verification
REQ-033 Reset, then wb0 valid number=5 value=32'hDEADBEEF -> wb0 ready same cycle; next cycle out_write_enable=1, number=5, value=32'hDEADBEEF; following cycle enable=0.
REQ-034 Both valid for 4 cycles (wb0 number=1, wb1 number=2), each held until accepted, RR enabled -> grants wb0, wb1, wb0, wb1; RR disabled -> wb0 every cycle.
REQ-035 Issue number=7, then in_reg_number_1=7 -> out_busy_1=1 from next cycle until the cycle after a transfer to register 7, then 0.
REQ-036 Issue number=9 in the same cycle as an accepted transfer to 9 -> pending[9]=1 afterwards; out_busy_2 with in_reg_number_2=9 reads 1.
REQ-037 wb1 valid number=0 value=32'h1 -> wb1 ready=1; next cycle out_write_enable=0; issue number=0 -> out_busy_1 with in_reg_number_1=0 stays 0.
REQ-038 Assert rst in the cycle after an accept to register 3 -> out_write_enable=0 immediately; pending bits and pointer read 0 after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-port write-back arbiter feeding one register-file write port, with a per-register pending scoreboard.
// Optional WB_ARB_RR_EN: round-robin between requesters; when undefined, requester 0 always wins.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_wb0_valid,
  input  logic [REG_BITS-1:0] in_wb0_number,
  input  logic [XLEN-1:0]     in_wb0_value,
  output logic                out_wb0_ready,
  input  logic                in_wb1_valid,
  input  logic [REG_BITS-1:0] in_wb1_number,
  input  logic [XLEN-1:0]     in_wb1_value,
  output logic                out_wb1_ready,
  input  logic                in_issue_valid,
  input  logic [REG_BITS-1:0] in_issue_number,
  input  logic [REG_BITS-1:0] in_reg_number_1,
  input  logic [REG_BITS-1:0] in_reg_number_2,
  output logic                out_busy_1,
  output logic                out_busy_2,
  output logic                out_write_enable,
  output logic [REG_BITS-1:0] out_write_number,
  output logic [XLEN-1:0]     out_write_value
);

  localparam int unsigned NUM_REGS = 1 << REG_BITS;

  logic                ptr_q;
  logic                gnt0;
  logic                gnt1;
  logic                xfer;
  logic                xfer_wr;
  logic [REG_BITS-1:0] sel_num;
  logic [XLEN-1:0]     sel_val;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

`ifdef WB_ARB_RR_EN
  // Pointer names the port that wins a tie; it moves to the loser after each tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (in_wb0_valid && in_wb1_valid) begin
      ptr_q <= ~ptr_q;
    end
  end
`else
  assign ptr_q = 1'b0;
`endif

  // Grant is purely a function of the two valids and the tie pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (in_wb0_valid && (!in_wb1_valid || !ptr_q)) begin
        gnt0 = 1'b1;
      end else if (in_wb1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign out_wb0_ready = gnt0;
  assign out_wb1_ready = gnt1;

  assign xfer    = gnt0 | gnt1;
  assign sel_num = gnt1 ? in_wb1_number : in_wb0_number;
  assign sel_val = gnt1 ? in_wb1_value  : in_wb0_value;
  // Writes to register 0 are accepted but never reach the register file.
  assign xfer_wr = xfer && (sel_num != '0);

  // One-cycle registered write strobe; index and data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_write_enable <= 1'b0;
      out_write_number <= '0;
      out_write_value  <= '0;
    end else begin
      out_write_enable <= xfer_wr;
      if (xfer_wr) begin
        out_write_number <= sel_num;
        out_write_value  <= sel_val;
      end
    end
  end

  // Set is applied after clear so a same-cycle issue keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    if (xfer_wr) begin
      pending_d[sel_num] = 1'b0;
    end
    if (in_issue_valid) begin
      pending_d[in_issue_number] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign out_busy_1 = pending_q[in_reg_number_1];
  assign out_busy_2 = pending_q[in_reg_number_2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected write-port results are queued as requests
// are driven and popped one cycle later; grants and busy flags come from a small bench model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [4:0]  wb0_number, wb1_number;
  logic [31:0] wb0_value, wb1_value;
  logic        issue_valid;
  logic [4:0]  issue_number, reg1, reg2;
  logic        busy1, busy2;
  logic        we;
  logic [4:0]  wnum;
  logic [31:0] wval;

  regfile_wb_arbiter #(.XLEN(32), .REG_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .in_wb0_valid(wb0_valid), .in_wb0_number(wb0_number), .in_wb0_value(wb0_value),
    .out_wb0_ready(wb0_ready),
    .in_wb1_valid(wb1_valid), .in_wb1_number(wb1_number), .in_wb1_value(wb1_value),
    .out_wb1_ready(wb1_ready),
    .in_issue_valid(issue_valid), .in_issue_number(issue_number),
    .in_reg_number_1(reg1), .in_reg_number_2(reg2),
    .out_busy_1(busy1), .out_busy_2(busy2),
    .out_write_enable(we), .out_write_number(wnum), .out_write_value(wval)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  num;
    logic [31:0] val;
  } wr_t;

  wr_t         exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        m_ptr;
  logic [31:0] m_pending;
  logic [4:0]  m_num;
  logic [31:0] m_val;
  logic        obs_r0, obs_r1;
  logic [3:0]  seq;
  logic [3:0]  exp_seq;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr     = 1'b0;
    m_pending = '0;
    m_num     = '0;
    m_val     = '0;
    exp_q.delete();
    exp_q.push_back('{we: 1'b0, num: 5'd0, val: 32'd0});
  endtask

  // Check one cycle against the model, queue next cycle's write, then advance past the edge.
  task automatic cycle();
    logic        g0, g1;
    logic [4:0]  sn;
    logic [31:0] sv;
    wr_t         e, n;
    #2;
    g0 = wb0_valid && (!wb1_valid || !m_ptr);
    g1 = wb1_valid && !g0;
    obs_r0 = wb0_ready;
    obs_r1 = wb1_ready;
    chk("ready0", 64'(wb0_ready), 64'(g0));
    chk("ready1", 64'(wb1_ready), 64'(g1));
    chk("busy1", 64'(busy1), 64'(m_pending[reg1]));
    chk("busy2", 64'(busy2), 64'(m_pending[reg2]));
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL queue_underflow: observed empty expected entry");
    end else begin
      e = exp_q.pop_front();
      chk("write_enable", 64'(we), 64'(e.we));
      chk("write_number", 64'(wnum), 64'(e.num));
      chk("write_value", 64'(wval), 64'(e.val));
    end
    sn = g1 ? wb1_number : wb0_number;
    sv = g1 ? wb1_value : wb0_value;
    n.we = (g0 || g1) && (sn != 5'd0);
    if (n.we) begin
      m_num = sn;
      m_val = sv;
    end
    n.num = m_num;
    n.val = m_val;
    exp_q.push_back(n);
    if (n.we) m_pending[sn] = 1'b0;
    if (issue_valid) m_pending[issue_number] = 1'b1;
    m_pending[0] = 1'b0;
`ifdef WB_ARB_RR_EN
    if (wb0_valid && wb1_valid) m_ptr = ~m_ptr;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wb0_valid = 1'b1; wb0_number = 5'd4; wb0_value = 32'h1234;
    wb1_valid = 1'b1; wb1_number = 5'd6; wb1_value = 32'h5678;
    issue_valid = 1'b1; issue_number = 5'd4; reg1 = 5'd4; reg2 = 5'd6;
    repeat (2) @(posedge clk);
    #1;
    // Reset holds everything quiet even with requests presented.
    chk("rst_ready0", 64'(wb0_ready), 64'd0);
    chk("rst_ready1", 64'(wb1_ready), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_wnum", 64'(wnum), 64'd0);
    chk("rst_wval", 64'(wval), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    rst = 1'b0;
    wb0_valid = 1'b0; wb1_valid = 1'b0; issue_valid = 1'b0;
    model_reset();

    // Single request to register 5.
    wb0_valid = 1'b1; wb0_number = 5'd5; wb0_value = 32'hDEADBEEF;
    cycle();
    chk("t1_ready0", 64'(obs_r0), 64'd1);
    wb0_valid = 1'b0;
    #2;
    chk("t1_we", 64'(we), 64'd1);
    chk("t1_wnum", 64'(wnum), 64'd5);
    chk("t1_wval", 64'(wval), 64'hDEADBEEF);
    cycle();
    cycle();

    // Both requesters contend for four cycles; the winner presents a fresh value after acceptance.
    wb0_valid = 1'b1; wb0_number = 5'd1; wb0_value = 32'hA000_0000;
    wb1_valid = 1'b1; wb1_number = 5'd2; wb1_value = 32'hB000_0000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      seq[i] = obs_r1;
      if (obs_r0) wb0_value = wb0_value + 32'd1;
      if (obs_r1) wb1_value = wb1_value + 32'd1;
    end
`ifdef WB_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    chk("t2_grant_seq", 64'(seq), 64'(exp_seq));
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    cycle();
    cycle();

    // Issue to register 7, then retire it.
    issue_valid = 1'b1; issue_number = 5'd7; reg1 = 5'd7; reg2 = 5'd0;
    cycle();
    issue_valid = 1'b0;
    cycle();
    chk("t3_busy_set", 64'(busy1), 64'd1);
    wb0_valid = 1'b1; wb0_number = 5'd7; wb0_value = 32'h77;
    cycle();
    wb0_valid = 1'b0;
    cycle();
    chk("t3_busy_clear", 64'(busy1), 64'd0);

    // Issue and retire of register 9 in the same cycle leaves it pending.
    issue_valid = 1'b1; issue_number = 5'd9; reg2 = 5'd9;
    cycle();
    wb1_valid = 1'b1; wb1_number = 5'd9; wb1_value = 32'h99;
    cycle();
    wb1_valid = 1'b0; issue_valid = 1'b0;
    cycle();
    chk("t4_busy2_set_wins", 64'(busy2), 64'd1);

    // Register 0: write dropped, never marked pending.
    wb1_valid = 1'b1; wb1_number = 5'd0; wb1_value = 32'h1;
    issue_valid = 1'b1; issue_number = 5'd0; reg1 = 5'd0;
    cycle();
    chk("t5_ready1", 64'(obs_r1), 64'd1);
    wb1_valid = 1'b0; issue_valid = 1'b0;
    cycle();
    chk("t5_busy0", 64'(busy1), 64'd0);

    // Reset right after an accept to register 3; tie first so the pointer is nonzero in RR builds.
    issue_valid = 1'b1; issue_number = 5'd3; reg1 = 5'd3;
    wb0_valid = 1'b1; wb0_number = 5'd1; wb0_value = 32'h11;
    wb1_valid = 1'b1; wb1_number = 5'd2; wb1_value = 32'h22;
    cycle();
    issue_valid = 1'b0; wb1_valid = 1'b0;
    wb0_number = 5'd3; wb0_value = 32'h33;
    cycle();
    chk("t6_we_before", 64'(we), 64'd1);
    chk("t6_wnum_before", 64'(wnum), 64'd3);
    rst = 1'b1;
    wb1_valid = 1'b1;
    #1;
    chk("t6_rst_we", 64'(we), 64'd0);
    chk("t6_rst_wnum", 64'(wnum), 64'd0);
    chk("t6_rst_wval", 64'(wval), 64'd0);
    chk("t6_rst_ready0", 64'(wb0_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    wb0_number = 5'd1; wb0_value = 32'h44;
    wb1_number = 5'd2; wb1_value = 32'h55;
    reg2 = 5'd9;
    cycle();
    chk("t6_ptr_reset_ready0", 64'(obs_r0), 64'd1);
    chk("t6_busy3_cleared", 64'(busy1), 64'd0);
    chk("t6_busy9_cleared", 64'(busy2), 64'd0);
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
